// File: rtl/reflet_int_controller_if.sv
// Interface bundle between the reflet CPU and its interrupt controller.
// master = CPU side (drives lines/PC/handshake), slave = controller side.
interface reflet_int_controller_if #(
  parameter int WORDSIZE   = 16,
  parameter int INT_NUMBER = 4
);
  localparam int SW = $clog2(INT_NUMBER);
  localparam int LW = $clog2(INT_NUMBER + 1);

  logic [INT_NUMBER-1:0] ext_int;
  logic [INT_NUMBER-1:0] int_mode;
  logic [INT_NUMBER-1:0] int_mask;
  logic [WORDSIZE-1:0]   program_counter;
  logic                  cpu_update;
  logic                  retint;
  logic                  rout_we;
  logic [SW-1:0]         rout_sel;
  logic [WORDSIZE-1:0]   rout_data;
  logic                  int_req;
  logic [WORDSIZE-1:0]   int_routine;
  logic [WORDSIZE-1:0]   ret_addr;
  logic [LW-1:0]         cur_level;
  logic                  stack_full;
  logic                  underflow;

  modport master (
    output ext_int, int_mode, int_mask,
    output program_counter, cpu_update, retint,
    output rout_we, rout_sel, rout_data,
    input  int_req, int_routine, ret_addr,
    input  cur_level, stack_full, underflow
  );

  modport slave (
    input  ext_int, int_mode, int_mask,
    input  program_counter, cpu_update, retint,
    input  rout_we, rout_sel, rout_data,
    output int_req, int_routine, ret_addr,
    output cur_level, stack_full, underflow
  );
endinterface

// File: rtl/reflet_int_controller.sv
// Nested prioritised interrupt controller (line 0 highest), level/edge lines,
// per-line routine table and PC/level nesting stack. Ports: clk, reset, bus.
module reflet_int_controller #(
  parameter int wordsize    = 16,
  parameter int int_number  = 4,
  parameter int stack_depth = 4
) (
  input logic clk,
  input logic reset,
  reflet_int_controller_if.slave bus
);
  localparam int W  = wordsize;
  localparam int N  = int_number;
  localparam int SW = $clog2(N);
  localparam int LW = $clog2(N + 1);
  localparam int DW = $clog2(stack_depth + 1);

  logic [N-1:0]  prev_q, pend_q, pend_d;
  logic [N-1:0]  pend_eff, req, take;
  logic [LW-1:0] lvl_q, lvl_d, target;
  logic [DW-1:0] dep_q, dep_d;
  logic [W-1:0]  rout_q [N];
  logic [W-1:0]  spc_q [stack_depth];
  logic [W-1:0]  spc_d [stack_depth];
  logic [LW-1:0] slv_q [stack_depth];
  logic [LW-1:0] slv_d [stack_depth];
  logic [W-1:0]  routine;
  logic          unf_q, unf_d;
  logic          full, push, pop;

  // Edge lines use the latch, level lines the live input.
  always_comb begin
    pend_eff = (bus.int_mode & pend_q)
             | (~bus.int_mode & bus.ext_int);
    req      = pend_eff & bus.int_mask;
    target   = LW'(N);
    routine  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        target  = LW'(i);
        routine = rout_q[i];
      end
    end
  end

  assign full = (dep_q == DW'(stack_depth));
  assign push = bus.cpu_update && (target < lvl_q) && !full;
  assign pop  = bus.cpu_update && bus.retint && !push;

  // A new edge wins over the clear of the line being taken;
  // level-mode lines never hold a latch.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      take[i] = push && (target == LW'(i));
    end
    pend_d = ((pend_q & ~take) | (bus.ext_int & ~prev_q))
           & bus.int_mode;
  end

  // Shift-register stack: entry 0 is always the top.
  always_comb begin
    spc_d = spc_q;
    slv_d = slv_q;
    dep_d = dep_q;
    lvl_d = lvl_q;
    unf_d = unf_q;
    if (push) begin
      for (int i = stack_depth - 1; i > 0; i--) begin
        spc_d[i] = spc_q[i-1];
        slv_d[i] = slv_q[i-1];
      end
      spc_d[0] = bus.program_counter;
      slv_d[0] = lvl_q;
      dep_d    = dep_q + DW'(1);
      lvl_d    = target;
    end else if (pop) begin
      if (dep_q != '0) begin
        for (int i = 0; i < stack_depth - 1; i++) begin
          spc_d[i] = spc_q[i+1];
          slv_d[i] = slv_q[i+1];
        end
        lvl_d = slv_q[0];
        dep_d = dep_q - DW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= '0;
      pend_q <= '0;
      lvl_q  <= LW'(N);
      dep_q  <= '0;
      unf_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        rout_q[i] <= '0;
      end
      for (int i = 0; i < stack_depth; i++) begin
        spc_q[i] <= '0;
        slv_q[i] <= '0;
      end
    end else begin
      prev_q <= bus.ext_int;
      pend_q <= pend_d;
      lvl_q  <= lvl_d;
      dep_q  <= dep_d;
      unf_q  <= unf_d;
      spc_q  <= spc_d;
      slv_q  <= slv_d;
      for (int i = 0; i < N; i++) begin
        if (bus.rout_we && bus.rout_sel == SW'(i)) begin
          rout_q[i] <= bus.rout_data;
        end
      end
    end
  end

  assign bus.int_req     = push;
  assign bus.int_routine = routine;
  assign bus.ret_addr    = (dep_q != '0) ? spc_q[0] : '0;
  assign bus.cur_level   = lvl_q;
  assign bus.stack_full  = full;
  assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_reflet_int_controller.sv
// Directed bench for reflet_int_controller (4 lines, nesting depth 2).
// Inputs change 1 time unit after the rising edge.
module tb_reflet_int_controller;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reflet_int_controller_if #(.WORDSIZE(16), .INT_NUMBER(4)) bus ();

  reflet_int_controller #(
    .wordsize(16), .int_number(4), .stack_depth(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset               = 1'b0;
    bus.ext_int         = '0;
    bus.int_mode        = '0;
    bus.int_mask        = '0;
    bus.program_counter = '0;
    bus.cpu_update      = 1'b0;
    bus.retint          = 1'b0;
    bus.rout_we         = 1'b0;
    bus.rout_sel        = '0;
    bus.rout_data       = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_level", 32'(bus.cur_level), 4);
    chk("rst_ret", 32'(bus.ret_addr), 0);
    chk("rst_req", 32'(bus.int_req), 0);
    chk("rst_full", 32'(bus.stack_full), 0);
    chk("rst_unf", 32'(bus.underflow), 0);

    // T1: single level interrupt on line 2
    bus.rout_we = 1'b1;
    bus.rout_sel = 2'd2;
    bus.rout_data = 16'h0120;
    tick();
    bus.rout_sel = 2'd0;
    bus.rout_data = 16'h0200;
    tick();
    bus.rout_we = 1'b0;
    bus.int_mask = 4'b0100;
    bus.ext_int = 4'b0100;
    bus.cpu_update = 1'b1;
    bus.program_counter = 16'h0040;
    #1;
    chk("t1_req", 32'(bus.int_req), 1);
    chk("t1_rout", 32'(bus.int_routine), 32'h0120);
    tick();
    chk("t1_level", 32'(bus.cur_level), 2);
    chk("t1_ret", 32'(bus.ret_addr), 32'h0040);
    chk("t1_noreq", 32'(bus.int_req), 0);

    // T2: nest line 0 inside level 2, then unwind
    bus.int_mask = 4'b0101;
    bus.ext_int = 4'b0101;
    bus.program_counter = 16'h0125;
    #1;
    chk("t2_req", 32'(bus.int_req), 1);
    chk("t2_rout", 32'(bus.int_routine), 32'h0200);
    tick();
    chk("t2_level0", 32'(bus.cur_level), 0);
    chk("t2_ret0", 32'(bus.ret_addr), 32'h0125);
    chk("t2_full", 32'(bus.stack_full), 1);
    bus.ext_int = 4'b0000;
    bus.retint = 1'b1;
    #1;
    chk("t2_ret_pres", 32'(bus.ret_addr), 32'h0125);
    tick();
    chk("t2_pop1_lvl", 32'(bus.cur_level), 2);
    chk("t2_pop1_ret", 32'(bus.ret_addr), 32'h0040);
    tick();
    chk("t2_pop2_lvl", 32'(bus.cur_level), 4);
    chk("t2_pop2_ret", 32'(bus.ret_addr), 0);
    chk("t2_pop2_full", 32'(bus.stack_full), 0);
    chk("t2_unf", 32'(bus.underflow), 0);
    bus.retint = 1'b0;

    // T3: edge line 1, pulse while CPU busy
    bus.int_mask = 4'b0010;
    bus.int_mode = 4'b0010;
    bus.cpu_update = 1'b0;
    bus.ext_int = 4'b0010;
    tick();
    bus.ext_int = 4'b0000;
    tick();
    chk("t3_held", 32'(bus.int_req), 0);
    bus.cpu_update = 1'b1;
    #1;
    chk("t3_req", 32'(bus.int_req), 1);
    tick();
    chk("t3_level", 32'(bus.cur_level), 1);
    bus.retint = 1'b1;
    tick();
    chk("t3_back", 32'(bus.cur_level), 4);
    bus.retint = 1'b0;
    #1;
    chk("t3_cleared", 32'(bus.int_req), 0);
    bus.ext_int = 4'b0010;
    #1;
    chk("t3_edge_lat", 32'(bus.int_req), 0);
    tick();
    chk("t3_req2", 32'(bus.int_req), 1);
    tick();
    chk("t3_level2", 32'(bus.cur_level), 1);
    bus.retint = 1'b1;
    tick();
    bus.retint = 1'b0;
    tick();
    chk("t3_noretrig", 32'(bus.int_req), 0);
    chk("t3_lvl4", 32'(bus.cur_level), 4);
    bus.ext_int = 4'b0000;
    bus.int_mode = 4'b0000;
    bus.int_mask = 4'b0000;
    tick();

    // T4: fill the depth-2 stack, line 0 blocked
    bus.int_mask = 4'b1000;
    bus.ext_int = 4'b1000;
    bus.program_counter = 16'h0300;
    tick();
    chk("t4_lvl3", 32'(bus.cur_level), 3);
    bus.int_mask = 4'b1100;
    bus.ext_int = 4'b1100;
    bus.program_counter = 16'h0310;
    tick();
    chk("t4_lvl2", 32'(bus.cur_level), 2);
    chk("t4_full", 32'(bus.stack_full), 1);
    bus.int_mask = 4'b1101;
    bus.ext_int = 4'b1101;
    #1;
    chk("t4_blocked", 32'(bus.int_req), 0);
    bus.retint = 1'b1;
    tick();
    bus.retint = 1'b0;
    chk("t4_pop_lvl", 32'(bus.cur_level), 3);
    chk("t4_pop_ret", 32'(bus.ret_addr), 32'h0300);
    #1;
    chk("t4_req", 32'(bus.int_req), 1);
    chk("t4_rout", 32'(bus.int_routine), 32'h0200);
    tick();
    chk("t4_lvl0", 32'(bus.cur_level), 0);

    // T6: reset while nested two deep, with an edge latch pending
    bus.int_mask = 4'b0000;
    bus.int_mode = 4'b0010;
    bus.ext_int = 4'b0010;
    tick();
    bus.ext_int = 4'b0000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.int_mask = 4'b0010;
    #1;
    chk("t6_level", 32'(bus.cur_level), 4);
    chk("t6_full", 32'(bus.stack_full), 0);
    chk("t6_ret", 32'(bus.ret_addr), 0);
    chk("t6_pend", 32'(bus.int_req), 0);
    bus.int_mode = 4'b0000;
    bus.int_mask = 4'b0000;

    // T5: request and retint together, then empty-stack retint
    bus.int_mask = 4'b0100;
    bus.ext_int = 4'b0100;
    bus.program_counter = 16'h0444;
    bus.retint = 1'b1;
    #1;
    chk("t5_req", 32'(bus.int_req), 1);
    chk("t5_rout_rst", 32'(bus.int_routine), 0);
    tick();
    chk("t5_push_lvl", 32'(bus.cur_level), 2);
    chk("t5_push_ret", 32'(bus.ret_addr), 32'h0444);
    chk("t5_unf0", 32'(bus.underflow), 0);
    bus.ext_int = 4'b0000;
    tick();
    chk("t5_pop_lvl", 32'(bus.cur_level), 4);
    chk("t5_unf1", 32'(bus.underflow), 0);
    tick();
    chk("t5_unf", 32'(bus.underflow), 1);
    chk("t5_unf_lvl", 32'(bus.cur_level), 4);
    bus.retint = 1'b0;
    tick();
    chk("t5_sticky", 32'(bus.underflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
